// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: drives the active-low output-enable and load-enable strobes
// for the registers sharing the tri-state data bus. Each transfer drives the
// source register alone for SETTLE cycles, then holds one load cycle, then
// spends one cycle with the bus released before the next transfer.
// Optional feature: define BUS_XFER_BCAST_EN to add the BCAST port, which
// loads several destinations in the same load cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released, waiting for REQ
// DRIVE | OE_n[src] low, settle down-counter running
// LOAD  | OE_n[src] low and LOAD_n[dst] low for exactly one cycle
// DONE  | bus released, ACK high; REQ sampled on the edge leaving here
module bus_xfer_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int SETTLE   = 1,
  localparam int IDXW    = $clog2(NUM_REGS)
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                REQ,
  input  logic [IDXW-1:0]     SRC,
  input  logic [IDXW-1:0]     DST,
`ifdef BUS_XFER_BCAST_EN
  input  logic [NUM_REGS-1:0] BCAST,
`endif
  output logic                BUSY,
  output logic                ACK,
  output logic                ERR,
  output logic [NUM_REGS-1:0] OE_n,
  output logic [NUM_REGS-1:0] LOAD_n
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_LOAD, ST_DONE} state_t;

  localparam logic [IDXW:0]     NREGS_W   = (IDXW+1)'(NUM_REGS);
  localparam logic [3:0]        SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [NUM_REGS-1:0] ONE_HOT0 = NUM_REGS'(1);

  state_t              state_q, state_nxt;
  logic [IDXW-1:0]     src_q, src_nxt;
  logic [NUM_REGS-1:0] dmask_q, dmask_nxt;
  logic [3:0]          cnt_q, cnt_nxt;

  logic                req_valid;
  logic [NUM_REGS-1:0] req_dmask;
  logic                src_ok, dst_ok;

  logic [NUM_REGS-1:0] oe_n_nxt, load_n_nxt;
  logic                busy_nxt, ack_nxt, err_nxt;

  // Validate the incoming request and build its destination mask.
  always_comb begin
    src_ok    = ({1'b0, SRC} < NREGS_W);
    dst_ok    = ({1'b0, DST} < NREGS_W);
    req_dmask = ONE_HOT0 << DST;
    req_valid = src_ok && dst_ok && (SRC != DST);
`ifdef BUS_XFER_BCAST_EN
    // A non-zero broadcast mask replaces DST; the source may not load itself.
    if (BCAST != '0) begin
      req_dmask = BCAST;
      req_valid = src_ok && !BCAST[SRC];
    end
`endif
  end

  // Next-state logic, then the registered output values derived from it.
  always_comb begin
    state_nxt = state_q;
    src_nxt   = src_q;
    dmask_nxt = dmask_q;
    cnt_nxt   = cnt_q;
    err_nxt   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (REQ) begin
          if (req_valid) begin
            src_nxt   = SRC;
            dmask_nxt = req_dmask;
            cnt_nxt   = SETTLE_M1;
            state_nxt = ST_DRIVE;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          state_nxt = ST_LOAD;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt   = (state_nxt != ST_IDLE);
    ack_nxt    = (state_nxt == ST_DONE);
    oe_n_nxt   = '1;
    load_n_nxt = '1;
    if ((state_nxt == ST_DRIVE) || (state_nxt == ST_LOAD)) begin
      oe_n_nxt = ~(ONE_HOT0 << src_nxt);
    end
    if (state_nxt == ST_LOAD) begin
      load_n_nxt = ~dmask_nxt;
    end
  end

  // State, latched request and all outputs register here; CLR drops everything.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dmask_q <= '0;
      cnt_q   <= 4'd0;
      BUSY    <= 1'b0;
      ACK     <= 1'b0;
      ERR     <= 1'b0;
      OE_n    <= '1;
      LOAD_n  <= '1;
    end else begin
      state_q <= state_nxt;
      src_q   <= src_nxt;
      dmask_q <= dmask_nxt;
      cnt_q   <= cnt_nxt;
      BUSY    <= busy_nxt;
      ACK     <= ack_nxt;
      ERR     <= err_nxt;
      OE_n    <= oe_n_nxt;
      LOAD_n  <= load_n_nxt;
    end
  end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: two instances (SETTLE=1 and SETTLE=4) share the
// clock and reset; a vector table checks per-cycle strobe timing, a
// scoreboard checks transfer outcomes against a model register file, and
// invariant checks run every cycle.
module tb_bus_xfer_ctrl;

  localparam int NR = 4;
  localparam int S1 = 1;
  localparam int S4 = 4;

  logic       CLK = 1'b0;
  logic       CLR, REQ, req4;
  logic [1:0] SRC, DST;
`ifdef BUS_XFER_BCAST_EN
  logic [3:0] bcast;
`endif
  logic       busy1, ack1, err1, busy4, ack4, err4;
  logic [3:0] oe1, ld1, oe4, ld4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  bus_xfer_ctrl #(.NUM_REGS(NR), .SETTLE(S1)) dut (
    .CLK(CLK), .CLR(CLR), .REQ(REQ), .SRC(SRC), .DST(DST),
`ifdef BUS_XFER_BCAST_EN
    .BCAST(bcast),
`endif
    .BUSY(busy1), .ACK(ack1), .ERR(err1), .OE_n(oe1), .LOAD_n(ld1)
  );

  bus_xfer_ctrl #(.NUM_REGS(NR), .SETTLE(S4)) dut4 (
    .CLK(CLK), .CLR(CLR), .REQ(req4), .SRC(SRC), .DST(DST),
`ifdef BUS_XFER_BCAST_EN
    .BCAST(bcast),
`endif
    .BUSY(busy4), .ACK(ack4), .ERR(err4), .OE_n(oe4), .LOAD_n(ld4)
  );

  typedef struct {
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] bcast;
    logic       exp_err;
    logic [3:0] exp_oe;
    logic [3:0] exp_ld;
  } vec_t;

  typedef struct {
    logic       err;
    logic [3:0] dmask;
    logic [7:0] val;
  } sb_t;

  vec_t       vecs[$];
  sb_t        sbq[$];
  logic [7:0] reg_model[NR];
  logic [7:0] exp_regs[NR];
  logic [3:0] prev_oe1 = 4'hF;
  logic [3:0] prev_oe4 = 4'hF;

  localparam logic [3:0] B_OE [7] = '{4'b1110, 4'b1110, 4'b1111, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
  localparam logic [3:0] B_LD [7] = '{4'b1111, 4'b1101, 4'b1111, 4'b1111, 4'b0111, 4'b1111, 4'b1111};
  localparam logic       B_ACK[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic       B_BSY[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  function automatic vec_t mk(input logic [1:0] s, input logic [1:0] d, input logic [3:0] b,
                              input logic e, input logic [3:0] oe, input logic [3:0] ld);
    vec_t v;
    v.src = s; v.dst = d; v.bcast = b; v.exp_err = e; v.exp_oe = oe; v.exp_ld = ld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  // Expected outputs c cycles after the accepting edge, from the latency rules.
  task automatic exp_at(input int c, input int s, input vec_t v,
                        output logic [3:0] oe, output logic [3:0] ld,
                        output logic busy, output logic ack, output logic err);
    oe = 4'hF; ld = 4'hF; busy = 1'b0; ack = 1'b0; err = 1'b0;
    if (v.exp_err) begin
      err = (c == 1);
    end else if (c <= s + 1) begin
      oe   = v.exp_oe;
      busy = 1'b1;
      if (c == s + 1) ld = v.exp_ld;
    end else if (c == s + 2) begin
      ack  = 1'b1;
      busy = 1'b1;
    end
  endtask

  task automatic push_sb(input logic [1:0] s, input logic [1:0] d, input logic [3:0] b);
    sb_t        e;
    logic       valid;
    logic [3:0] m;
    if (b != 4'h0) begin
      m     = b;
      valid = !b[s];
    end else begin
      m     = 4'b0001 << d;
      valid = (s != d);
    end
    e.err   = !valid;
    e.dmask = m;
    e.val   = exp_regs[s];
    if (valid) begin
      for (int i = 0; i < NR; i++) if (m[i]) exp_regs[i] = exp_regs[s];
    end
    sbq.push_back(e);
  endtask

  task automatic drive_req(input logic r1, input logic r4, input vec_t v);
    REQ  = r1;
    req4 = r4;
    SRC  = v.src;
    DST  = v.dst;
`ifdef BUS_XFER_BCAST_EN
    bcast = v.bcast;
`endif
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_oe1"}, {4'h0, oe1}, 8'h0F);
    chk({tag, "_ld1"}, {4'h0, ld1}, 8'h0F);
    chk({tag, "_busy1"}, {7'h0, busy1}, 8'h00);
    chk({tag, "_ackerr1"}, {6'h0, ack1, err1}, 8'h00);
    chk({tag, "_oe4"}, {4'h0, oe4}, 8'h0F);
    chk({tag, "_ld4"}, {4'h0, ld4}, 8'h0F);
    chk({tag, "_busy4"}, {7'h0, busy4}, 8'h00);
    chk({tag, "_ackerr4"}, {6'h0, ack4, err4}, 8'h00);
  endtask

  // Single request on both instances, then per-cycle comparison for 7 cycles.
  task automatic run_vec(input int idx, input vec_t v);
    logic [3:0] eoe, eld;
    logic       eb, ea, ee;
    string      t;
    drive_req(1'b1, 1'b1, v);
    push_sb(v.src, v.dst, v.bcast);
    @(posedge CLK);
    @(negedge CLK);
    REQ  = 1'b0;
    req4 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      t = $sformatf("v%0d_c%0d", idx, c);
      exp_at(c, S1, v, eoe, eld, eb, ea, ee);
      chk({t, "_oe1"}, {4'h0, oe1}, {4'h0, eoe});
      chk({t, "_ld1"}, {4'h0, ld1}, {4'h0, eld});
      chk({t, "_bae1"}, {5'h0, busy1, ack1, err1}, {5'h0, eb, ea, ee});
      exp_at(c, S4, v, eoe, eld, eb, ea, ee);
      chk({t, "_oe4"}, {4'h0, oe4}, {4'h0, eoe});
      chk({t, "_ld4"}, {4'h0, ld4}, {4'h0, eld});
      chk({t, "_bae4"}, {5'h0, busy4, ack4, err4}, {5'h0, eb, ea, ee});
      @(negedge CLK);
    end
  endtask

  task automatic inv(input string nm, input logic [3:0] oe, input logic [3:0] ld,
                     input logic ack, input logic err, input logic [3:0] prev);
    n_checks++;
    if ($countones(~oe) > 1 || (ack && err)) begin
      n_fail++;
      $display("FAIL %s_one_driver: OE_n=%b ack=%b err=%b, required at most one low bit and no ack+err", nm, oe, ack, err);
    end
    n_checks++;
    if (ld != 4'hF && (oe == 4'hF || (~ld & ~oe) != 4'h0)) begin
      n_fail++;
      $display("FAIL %s_load_src: LOAD_n=%b OE_n=%b, required load only while another register drives", nm, ld, oe);
    end
    n_checks++;
    if (prev != 4'hF && oe != 4'hF && prev != oe) begin
      n_fail++;
      $display("FAIL %s_bbm: OE_n went %b -> %b, required an all-ones cycle between", nm, prev, oe);
    end
`ifndef BUS_XFER_BCAST_EN
    n_checks++;
    if ($countones(~ld) > 1) begin
      n_fail++;
      $display("FAIL %s_single_load: LOAD_n=%b, required at most one low bit", nm, ld);
    end
`endif
  endtask

  // Per-cycle invariants, scoreboard outcomes and the model register file.
  always @(negedge CLK) begin
    sb_t        e;
    logic [7:0] bus;
    inv("dut1", oe1, ld1, ack1, err1, prev_oe1);
    inv("dut4", oe4, ld4, ack4, err4, prev_oe4);
    prev_oe1 = oe1;
    prev_oe4 = oe4;
    if (!CLR && (ack1 || err1)) begin
      n_checks++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: ack=%b err=%b, required no outcome (nothing pending)", ack1, err1);
      end else begin
        e = sbq.pop_front();
        if (err1 !== e.err || ack1 !== !e.err) begin
          n_fail++;
          $display("FAIL sb_outcome: ack=%b err=%b, required ack=%b err=%b", ack1, err1, !e.err, e.err);
        end
        if (ack1 && !e.err) begin
          for (int i = 0; i < NR; i++)
            if (e.dmask[i]) chk($sformatf("sb_reg%0d", i), reg_model[i], e.val);
        end
      end
    end
    if (ld1 != 4'hF) begin
      bus = 8'h00;
      for (int i = 0; i < NR; i++) if (!oe1[i]) bus = reg_model[i];
      for (int i = 0; i < NR; i++) if (!ld1[i]) reg_model[i] = bus;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required the test to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < NR; i++) begin
      reg_model[i] = 8'(16 * i + 5);
      exp_regs[i]  = 8'(16 * i + 5);
    end
    v = mk(2'd0, 2'd0, 4'h0, 1'b0, 4'hF, 4'hF);
    CLR = 1'b1;
    drive_req(1'b0, 1'b0, v);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_idle("reset");
    CLR = 1'b0;
    @(negedge CLK);

    vecs.push_back(mk(2'd1, 2'd2, 4'h0, 1'b0, 4'b1101, 4'b1011));
    vecs.push_back(mk(2'd3, 2'd3, 4'h0, 1'b1, 4'b1111, 4'b1111));
    vecs.push_back(mk(2'd0, 2'd1, 4'h0, 1'b0, 4'b1110, 4'b1101));
    vecs.push_back(mk(2'd3, 2'd0, 4'h0, 1'b0, 4'b0111, 4'b1110));
    vecs.push_back(mk(2'd0, 2'd0, 4'h0, 1'b1, 4'b1111, 4'b1111));
    vecs.push_back(mk(2'd2, 2'd1, 4'h0, 1'b0, 4'b1011, 4'b1101));
    vecs.push_back(mk(2'd1, 2'd3, 4'h0, 1'b0, 4'b1101, 4'b0111));
`ifdef BUS_XFER_BCAST_EN
    vecs.push_back(mk(2'd0, 2'd2, 4'b1110, 1'b0, 4'b1110, 4'b0001));
    vecs.push_back(mk(2'd0, 2'd1, 4'b0011, 1'b1, 4'b1111, 4'b1111));
    vecs.push_back(mk(2'd2, 2'd2, 4'b0001, 1'b0, 4'b1011, 4'b1110));
`endif
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Back-to-back on the SETTLE=1 instance with REQ held high.
    v = mk(2'd0, 2'd1, 4'h0, 1'b0, 4'hF, 4'hF);
    drive_req(1'b1, 1'b0, v);
    push_sb(2'd0, 2'd1, 4'h0);
    @(posedge CLK);
    @(negedge CLK);
    SRC = 2'd2;
    DST = 2'd3;
    push_sb(2'd2, 2'd3, 4'h0);
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) REQ = 1'b0;
      if (c == 6) REQ = 1'b0;
      chk($sformatf("b2b_c%0d_oe", c), {4'h0, oe1}, {4'h0, B_OE[c-1]});
      chk($sformatf("b2b_c%0d_ld", c), {4'h0, ld1}, {4'h0, B_LD[c-1]});
      chk($sformatf("b2b_c%0d_bae", c), {5'h0, busy1, ack1, err1}, {5'h0, B_BSY[c-1], B_ACK[c-1], 1'b0});
      if (c == 5) begin
        REQ = 1'b1;
        SRC = 2'd3;
        DST = 2'd3;
      end
      @(negedge CLK);
    end

    // CLR for two edges while both instances are in DRIVE.
    v = mk(2'd1, 2'd2, 4'h0, 1'b0, 4'hF, 4'hF);
    drive_req(1'b1, 1'b1, v);
    @(posedge CLK);
    @(negedge CLK);
    REQ  = 1'b0;
    req4 = 1'b0;
    chk("clr_pre_oe1", {4'h0, oe1}, 8'h0D);
    chk("clr_pre_oe4", {4'h0, oe4}, 8'h0D);
    CLR = 1'b1;
    @(negedge CLK);
    check_idle("clr1");
    @(negedge CLK);
    check_idle("clr2");
    CLR = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      check_idle($sformatf("post_clr%0d", c));
    end

    run_vec(99, mk(2'd2, 2'd0, 4'h0, 1'b0, 4'b1011, 4'b1110));

    repeat (3) @(negedge CLK);
    chk("sb_empty", 8'(sbq.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
